// File: rtl/ps2_letter_decoder_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : enigma_pkg                                                       |
// | Brief    : Shared constants, types and FSM encoding for the PS/2 letter    |
// |            decoder and the rotor path.                                      |
// | Revision : 1.0                                                              |
// +----------------------------------------------------------------------------+
package enigma_pkg;

    localparam int NUM_LETTERS = 26;
    localparam int IDX_W       = 5;

    typedef logic [IDX_W-1:0]       letter_idx_t;
    typedef logic [NUM_LETTERS-1:0] letter_onehot_t;

    localparam logic [7:0] PS2_BREAK  = 8'hF0;
    localparam logic [7:0] PS2_EXT    = 8'hE0;
    localparam logic [7:0] PS2_PAUSE  = 8'hE1;
    localparam logic [7:0] PS2_BAT_OK = 8'hAA;
    localparam logic [7:0] PS2_ACK    = 8'hFA;
    localparam logic [7:0] PS2_RESEND = 8'hFE;
    localparam logic [7:0] PS2_ERR_LO = 8'h00;
    localparam logic [7:0] PS2_ERR_HI = 8'hFF;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BRK     = 2'd1,
        EXT     = 2'd2,
        EXT_BRK = 2'd3
    } ps2_state_t;

    function automatic letter_onehot_t idx_to_onehot(input letter_idx_t idx);
        letter_onehot_t w_one;
        w_one = {{(NUM_LETTERS-1){1'b0}}, 1'b1};
        return w_one << idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_letter_decoder_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : ps2_letter_decoder_if                                            |
// | Brief    : Scan-byte input and letter-event valid/ready output bundle.      |
// | Revision : 1.0                                                              |
// +----------------------------------------------------------------------------+
interface ps2_letter_decoder_if;

    logic                       scan_valid;
    logic [7:0]                 scan_code;
    logic                       letter_ready;
    logic                       letter_valid;
    enigma_pkg::letter_idx_t    letter_idx;
    enigma_pkg::letter_onehot_t letter_onehot;
    logic                       key_held;
    logic                       overflow;

    // master drives scan bytes and accepts letters; slave is the decoder
    modport master (
        output scan_valid, scan_code, letter_ready,
        input  letter_valid, letter_idx, letter_onehot, key_held, overflow
    );

    modport slave (
        input  scan_valid, scan_code, letter_ready,
        output letter_valid, letter_idx, letter_onehot, key_held, overflow
    );

endinterface
`default_nettype wire

// File: rtl/ps2_letter_decoder_scan_to_letter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : scan_to_letter                                                   |
// | Brief    : Combinational PS/2 set-2 scan code to letter index lookup.       |
// | Revision : 1.0                                                              |
// +----------------------------------------------------------------------------+
module scan_to_letter
    import enigma_pkg::*;
(
    input  wire logic [7:0]  i_scan_code,
    output logic             o_is_letter,
    output letter_idx_t      o_idx
);

    always_comb begin
        o_is_letter = 1'b1;
        o_idx       = '0;
        case (i_scan_code)
            8'h1C: o_idx = 5'd0;
            8'h32: o_idx = 5'd1;
            8'h21: o_idx = 5'd2;
            8'h23: o_idx = 5'd3;
            8'h24: o_idx = 5'd4;
            8'h2B: o_idx = 5'd5;
            8'h34: o_idx = 5'd6;
            8'h33: o_idx = 5'd7;
            8'h43: o_idx = 5'd8;
            8'h3B: o_idx = 5'd9;
            8'h42: o_idx = 5'd10;
            8'h4B: o_idx = 5'd11;
            8'h3A: o_idx = 5'd12;
            8'h31: o_idx = 5'd13;
            8'h44: o_idx = 5'd14;
            8'h4D: o_idx = 5'd15;
            8'h15: o_idx = 5'd16;
            8'h2D: o_idx = 5'd17;
            8'h1B: o_idx = 5'd18;
            8'h2C: o_idx = 5'd19;
            8'h3C: o_idx = 5'd20;
            8'h2A: o_idx = 5'd21;
            8'h1D: o_idx = 5'd22;
            8'h22: o_idx = 5'd23;
            8'h35: o_idx = 5'd24;
            8'h1A: o_idx = 5'd25;
            default: o_is_letter = 1'b0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/ps2_letter_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : ps2_letter_decoder                                               |
// | Brief    : Tracks PS/2 make/break/extended prefixes and emits one letter    |
// |            event per A-Z press over a valid/ready handshake.                |
// |            Define PS2_LETTER_TYPEMATIC_EN to emit events on key repeats.    |
// | Revision : 1.0                                                              |
// +----------------------------------------------------------------------------+
module ps2_letter_decoder
    import enigma_pkg::*;
(
    input  wire logic          clock,
    input  wire logic          reset,
    ps2_letter_decoder_if.slave bus
);

    ps2_state_t     r_state;
    letter_idx_t    r_held_idx;
    logic           r_key_held;
    logic           r_letter_valid;
    letter_idx_t    r_letter_idx;
    letter_onehot_t r_letter_onehot;
    logic           r_overflow;

    logic        w_is_letter;
    letter_idx_t w_idx;
    logic        w_accept;
    logic        w_make;
    logic        w_press;
    logic        w_can_load;

    scan_to_letter u_scan_to_letter (
        .i_scan_code (bus.scan_code),
        .o_is_letter (w_is_letter),
        .o_idx       (w_idx)
    );

    assign w_accept   = r_letter_valid & bus.letter_ready;
    assign w_make     = bus.scan_valid && (r_state == IDLE) && w_is_letter;
    assign w_can_load = !r_letter_valid || w_accept;

`ifdef PS2_LETTER_TYPEMATIC_EN
    assign w_press = w_make;
`else
    logic w_repeat;
    // a make for the letter already down is the keyboard's autorepeat
    assign w_repeat = r_key_held && (r_held_idx == w_idx);
    assign w_press  = w_make && !w_repeat;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state         <= IDLE;
            r_held_idx      <= '0;
            r_key_held      <= 1'b0;
            r_letter_valid  <= 1'b0;
            r_letter_idx    <= '0;
            r_letter_onehot <= '0;
            r_overflow      <= 1'b0;
        end else begin
            r_overflow <= 1'b0;

            if (w_accept) begin
                r_letter_valid  <= 1'b0;
                r_letter_onehot <= '0;
            end

            if (w_press) begin
                r_held_idx <= w_idx;
                r_key_held <= 1'b1;
                if (w_can_load) begin
                    r_letter_valid  <= 1'b1;
                    r_letter_idx    <= w_idx;
                    r_letter_onehot <= idx_to_onehot(w_idx);
                end else begin
                    r_overflow <= 1'b1;
                end
            end

            if (bus.scan_valid) begin
                case (r_state)
                    IDLE: begin
                        case (bus.scan_code)
                            PS2_BREAK: r_state <= BRK;
                            PS2_EXT:   r_state <= EXT;
                            default:   r_state <= IDLE;
                        endcase
                    end
                    BRK: begin
                        r_state <= IDLE;
                        if (w_is_letter && r_key_held && (r_held_idx == w_idx))
                            r_key_held <= 1'b0;
                    end
                    EXT: begin
                        r_state <= (bus.scan_code == PS2_BREAK) ? EXT_BRK : IDLE;
                    end
                    EXT_BRK: r_state <= IDLE;
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign bus.letter_valid  = r_letter_valid;
    assign bus.letter_idx    = r_letter_idx;
    assign bus.letter_onehot = r_letter_onehot;
    assign bus.key_held      = r_key_held;
    assign bus.overflow      = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_ps2_letter_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_ps2_letter_decoder                                            |
// | Brief    : Scoreboard bench for ps2_letter_decoder (PS2_LETTER_TYPEMATIC_EN |
// |            selects the repeat expectation).                                 |
// | Revision : 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_ps2_letter_decoder;
    import enigma_pkg::*;

    logic clock = 1'b0;
    logic reset;

    ps2_letter_decoder_if bus ();

    ps2_letter_decoder dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;
    int exp_q[$];
    int ovf_cnt  = 0;
    int xfer_cnt = 0;

    // transfers happen at the next posedge; inputs are stable across the negedge
    always @(negedge clock) begin
        int e;
        logic [NUM_LETTERS-1:0] exp_oh;
        if (reset !== 1'b1) begin
            if (bus.overflow === 1'b1) ovf_cnt++;
            if (bus.letter_valid === 1'b1 && bus.letter_ready === 1'b1) begin
                xfer_cnt++;
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_event: got idx=%0d, required no event", bus.letter_idx);
                end else begin
                    e      = exp_q.pop_front();
                    exp_oh = {{(NUM_LETTERS-1){1'b0}}, 1'b1} << e;
                    if (bus.letter_idx !== letter_idx_t'(e) || bus.letter_onehot !== exp_oh) begin
                        bad++;
                        $display("FAIL event: got idx=%0d onehot=%h, required idx=%0d onehot=%h",
                                 bus.letter_idx, bus.letter_onehot, e, exp_oh);
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish, required completion");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.scan_valid = 1'b1;
        bus.scan_code  = b;
        tick();
        bus.scan_valid = 1'b0;
        bus.scan_code  = 8'h00;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
        for (int i = 0; i < 4; i++) tick();
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL %s_drain: %0d events outstanding, required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.scan_valid = 1'b0;
        bus.scan_code = 8'h00;
        bus.letter_ready = 1'b1;
        tick();
        tick();
        total++;
        if ({bus.letter_valid, bus.letter_idx, bus.letter_onehot, bus.key_held, bus.overflow} !== '0) begin
            bad++;
            $display("FAIL reset_state: got v=%b idx=%0d oh=%h held=%b ovf=%b, required all 0",
                     bus.letter_valid, bus.letter_idx, bus.letter_onehot, bus.key_held, bus.overflow);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_make_break();
        bus.letter_ready = 1'b1;
        exp_q.push_back(0);
        send_byte(8'h1C);
        total++;
        if (bus.letter_valid !== 1'b1 || bus.letter_onehot !== 26'h0000001 || bus.key_held !== 1'b1) begin
            bad++;
            $display("FAIL make_latency: got v=%b oh=%h held=%b, required v=1 oh=0000001 held=1",
                     bus.letter_valid, bus.letter_onehot, bus.key_held);
        end
        tick();
        send_byte(8'hF0);
        send_byte(8'h1C);
        total++;
        if (bus.key_held !== 1'b0) begin
            bad++;
            $display("FAIL break_release: got key_held=%b, required 0", bus.key_held);
        end
        drain("make_break");
    endtask

    task automatic test_typematic();
        int x0;
        int n_exp;
        x0 = xfer_cnt;
`ifdef PS2_LETTER_TYPEMATIC_EN
        n_exp = 3;
`else
        n_exp = 1;
`endif
        for (int i = 0; i < n_exp; i++) exp_q.push_back(25);
        send_byte(8'h1A);
        send_byte(8'h1A);
        send_byte(8'h1A);
        send_byte(8'hF0);
        send_byte(8'h1A);
        drain("typematic");
        total++;
        if (xfer_cnt - x0 != n_exp || bus.key_held !== 1'b0) begin
            bad++;
            $display("FAIL typematic_count: got %0d events held=%b, required %0d events held=0",
                     xfer_cnt - x0, bus.key_held, n_exp);
        end
    endtask

    task automatic test_overflow();
        int x0;
        int o0;
        x0 = xfer_cnt;
        o0 = ovf_cnt;
        bus.letter_ready = 1'b0;
        exp_q.push_back(4);
        send_byte(8'h24);
        send_byte(8'h2D);
        total++;
        if (bus.overflow !== 1'b1 || bus.letter_idx !== 5'd4) begin
            bad++;
            $display("FAIL overflow_pulse: got ovf=%b idx=%0d, required ovf=1 idx=4",
                     bus.overflow, bus.letter_idx);
        end
        tick();
        tick();
        tick();
        total++;
        if (bus.overflow !== 1'b0 || bus.letter_valid !== 1'b1 || bus.letter_idx !== 5'd4
            || bus.letter_onehot !== 26'h0000010 || ovf_cnt - o0 != 1) begin
            bad++;
            $display("FAIL overflow_hold: got ovf=%b v=%b idx=%0d oh=%h pulses=%0d, required 0 1 4 0000010 1",
                     bus.overflow, bus.letter_valid, bus.letter_idx, bus.letter_onehot, ovf_cnt - o0);
        end
        bus.letter_ready = 1'b1;
        drain("overflow");
        total++;
        if (xfer_cnt - x0 != 1 || bus.letter_valid !== 1'b0) begin
            bad++;
            $display("FAIL overflow_single: got %0d transfers v=%b, required 1 transfer v=0",
                     xfer_cnt - x0, bus.letter_valid);
        end
        send_byte(8'hF0);
        send_byte(8'h2D);
        total++;
        if (bus.key_held !== 1'b0) begin
            bad++;
            $display("FAIL overflow_held_idx: got key_held=%b, required 0", bus.key_held);
        end
    endtask

    task automatic test_non_letter();
        int x0;
        logic [7:0] seq [8];
        seq = '{8'hE0, 8'h75, 8'hE0, 8'hF0, 8'h75, 8'h5A, 8'hAA, 8'hFA};
        exp_q.push_back(0);
        send_byte(8'h1C);
        drain("non_letter_pre");
        x0 = xfer_cnt;
        foreach (seq[i]) send_byte(seq[i]);
        tick();
        tick();
        total++;
        if (bus.key_held !== 1'b1 || xfer_cnt != x0 || bus.letter_valid !== 1'b0) begin
            bad++;
            $display("FAIL non_letter: got held=%b events=%0d v=%b, required held=1 events=0 v=0",
                     bus.key_held, xfer_cnt - x0, bus.letter_valid);
        end
        send_byte(8'hF0);
        send_byte(8'h1C);
        total++;
        if (bus.key_held !== 1'b0) begin
            bad++;
            $display("FAIL non_letter_idle: got key_held=%b, required 0", bus.key_held);
        end
    endtask

    task automatic test_back_to_back();
        exp_q.push_back(0);
        exp_q.push_back(1);
        send_byte(8'h1C);
        send_byte(8'h32);
        send_byte(8'hF0);
        send_byte(8'h1C);
        total++;
        if (bus.key_held !== 1'b1) begin
            bad++;
            $display("FAIL b2b_held: got key_held=%b, required 1", bus.key_held);
        end
        send_byte(8'hF0);
        send_byte(8'h32);
        total++;
        if (bus.key_held !== 1'b0) begin
            bad++;
            $display("FAIL b2b_release: got key_held=%b, required 0", bus.key_held);
        end
        drain("back_to_back");
    endtask

    task automatic test_reset_mid();
        int x0;
        send_byte(8'hF0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        exp_q.push_back(0);
        send_byte(8'h1C);
        total++;
        if (bus.letter_valid !== 1'b1 || bus.letter_idx !== 5'd0) begin
            bad++;
            $display("FAIL reset_mid: got v=%b idx=%0d, required v=1 idx=0", bus.letter_valid, bus.letter_idx);
        end
        drain("reset_mid");
        x0 = xfer_cnt;
        reset = 1'b1;
        bus.scan_valid = 1'b1;
        bus.scan_code = 8'h1C;
        tick();
        reset = 1'b0;
        bus.scan_valid = 1'b0;
        bus.scan_code = 8'h00;
        tick();
        tick();
        total++;
        if (bus.letter_valid !== 1'b0 || bus.key_held !== 1'b0 || xfer_cnt != x0) begin
            bad++;
            $display("FAIL reset_coincident: got v=%b held=%b events=%0d, required 0 0 0",
                     bus.letter_valid, bus.key_held, xfer_cnt - x0);
        end
    endtask

    initial begin
        test_reset();
        test_make_break();
        test_typematic();
        test_overflow();
        test_non_letter();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ps2_letter_decoder.md
Name: ps2_letter_decoder

Overview:
Sits between the PS/2 byte receiver and the rotor stage. Consumes raw scan-code bytes and tracks the make, break and extended prefixes. Emits exactly one letter event per physical press of A–Z, held until the rotor path accepts it via a valid/ready handshake. Typematic repeats, releases, non-letter keys and extended keys produce no event.

Parameters:
NUM_LETTERS, 26, number of letter symbols; one-hot output width.
IDX_W, 5, width of the binary letter index.

Ports:
clock  in  1  system clock (50 MHz domain).
reset  in  1  synchronous, active-high; clears all state.
scan_valid  in  1  one-cycle strobe; scan_code holds a new byte, already synchronised to clock.
scan_code  in  8  received PS/2 set-2 byte.
letter_ready  in  1  downstream accepts the event when high while letter_valid is high.
letter_valid  out  1  a letter event is pending.
letter_idx  out  IDX_W  binary index (A=0 … Z=25); valid only while letter_valid.
letter_onehot  out  NUM_LETTERS  one-hot of letter_idx; all-zero while letter_valid is low.
key_held  out  1  a letter key is currently held down.
overflow  out  1  one-cycle pulse: a new press was dropped because an event was already pending and not accepted.

Behaviour:
- Reset values: letter_valid=0, letter_idx=0, letter_onehot=0, key_held=0, overflow=0, FSM=IDLE, held_idx=0.
- All state updates only on a cycle with scan_valid=1, except the handshake and the overflow pulse.
- FSM states, on scan_valid:
  - IDLE:
    - 0xF0 → BRK.
    - 0xE0 → EXT.
    - 0xE1, 0xAA, 0xFA, 0xFE, 0x00, 0xFF → IDLE, ignored.
    - letter code → make handling, stay IDLE.
    - any other code → IDLE, ignored.
  - BRK: any byte → IDLE. If the byte is a letter code equal to held_idx while key_held=1, clear key_held. Otherwise ignore.
  - EXT: 0xF0 → EXT_BRK; any other byte → IDLE, ignored.
  - EXT_BRK: any byte → IDLE, ignored.
- Make handling for letter L:
  - key_held=1 and held_idx==L: typematic repeat; suppressed, no event.
  - Otherwise: held_idx←L, key_held←1, then attempt to load event L.
- Event load:
  - Loaded if letter_valid=0, or letter_valid=1 and letter_ready=1 in that same cycle (accept and reload simultaneously).
  - Otherwise the new event is dropped; the pending event is unchanged; overflow=1 next cycle only. held_idx/key_held still update.
- Latency: letter_valid rises the cycle after the scan_valid that carried the make byte.
- Handshake:
  - Transfer occurs when letter_valid & letter_ready.
  - letter_valid clears the next cycle unless a reload happens.
  - letter_idx and letter_onehot are stable while letter_valid=1 and not transferred.
- letter_onehot = (1 << letter_idx) when letter_valid, else 0.
- Scan-code map (set 2):
  - A 1C, B 32, C 21, D 23, E 24, F 2B, G 34, H 33, I 43.
  - J 3B, K 42, L 4B, M 3A, N 31, O 44, P 4D, Q 15, R 2D.
  - S 1B, T 2C, U 3C, V 2A, W 1D, X 22, Y 35, Z 1A.
- Reset in the same cycle as scan_valid: reset wins and the byte is discarded.
- Reset mid-sequence, e.g. after 0xF0: returns to IDLE; the next byte is interpreted fresh.

Optional Feature:
Macro PS2_LETTER_TYPEMATIC_EN.
- Defined: repeated make codes for the held letter each generate an event, subject to the same load/drop rules.
- Undefined (default): repeats are suppressed as described above.

Decomposition:
- Shared package enigma_pkg:
  - NUM_LETTERS and IDX_W constants.
  - Letter index type.
  - Scan-code constants: PS2_BREAK=0xF0, PS2_EXT=0xE0, PS2_PAUSE=0xE1, PS2_BAT_OK=0xAA, PS2_ACK=0xFA, PS2_RESEND=0xFE.
  - FSM state enum {IDLE, BRK, EXT, EXT_BRK}.
- One sub-module, scan_to_letter: purely combinational lookup from scan_code[7:0] to {is_letter, idx[4:0]}.

Test Plan:
- After reset, bytes 1C with letter_ready=1 → letter_valid=1 one cycle later; idx=0; onehot=0x0000001; key_held=1. F0 1C → key_held=0, no event.
- 1A, 1A, 1A (typematic), then F0 1A → exactly one event, idx=25, onehot=0x2000000. With PS2_LETTER_TYPEMATIC_EN defined: three events.
- letter_ready=0: 24 then 2D → event idx=4 held stable and overflow pulses once. Raise letter_ready → single transfer of idx=4; idx=17 is never emitted.
- E0 75 (up arrow), E0 F0 75, 5A (enter), AA, FA → no events; key_held unchanged; FSM back in IDLE.
- Press 1C, press 32 while A is held, then F0 1C → events idx=0 then idx=1; key_held stays 1 because held_idx=1. F0 32 → key_held=0.
- Bytes F0, then reset pulse, then 1C → event idx=0 (the F0 is discarded). Reset asserted coincident with a scan_valid carrying 1C → no event.
